// File: rtl/motor_pwm_drive.sv
// -----------------------------------------------------------------------------
// motor_pwm_drive
//   Two-channel (left/right) PWM driver for an L298-style H-bridge. It takes the
//   static enable/in1/in2 levels from the key-to-motor command decoder and turns
//   them into PWM on the bridge pins. Each channel has:
//     - soft-start and soft-stop duty ramps,
//     - a dead-time of DEAD_PER PWM periods before every direction reversal and
//       after every brake release,
//     - an immediate brake (both pins high) that is not tied to the PWM period.
//   Both channels share one prescaler and one 8-bit PWM counter.
//
// Parameters
//   PRESCALE   clk cycles per PWM counter step (>=1); period = PRESCALE*256 clk
//   RAMP_STEP  duty change applied once per PWM period (1..255)
//   DUTY_MAX   ramp target duty (8 bit); 255 gives 255/256 on-time
//   DEAD_PER   PWM periods with both pins low before re-driving (>=1)
//
// Ports
//   clk                  in   system clock
//   rst_n                in   synchronous reset, active low
//   en_l, in1_l, in2_l   in   left command: en=0 or 00 stop, 10 fwd, 01 rev, 11 brake
//   en_r, in1_r, in2_r   in   right command, same encoding
//   speed_l, speed_r     in   [7:0] per-channel ramp target (MOTOR_SPEED_IN_EN only)
//   pwm_la, pwm_lb       out  left bridge pins A (fwd PWM) / B (rev PWM)
//   pwm_ra, pwm_rb       out  right bridge pins A / B
//   moving               out  either channel has non-zero duty or is in dead time
//
// Build option
//   MOTOR_SPEED_IN_EN    when defined, adds speed_l/speed_r; the live speed value
//                        replaces DUTY_MAX as ramp target, and speed 0 means stop.
// -----------------------------------------------------------------------------

// One bridge channel: ramp FSM, duty register and pin generation.
module motor_pwm_chan #(
    parameter int unsigned RAMP_STEP = 8,
    parameter int unsigned DEAD_PER  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] cmd_i,      // 0 stop, 1 fwd, 2 rev, 3 brake
    input  logic [7:0] target_i,   // ramp target duty
    input  logic       per_end_i,  // last tick of the PWM period
    input  logic [7:0] pwm_cnt_i,
    output logic       pin_a_o,
    output logic       pin_b_o,
    output logic       moving_o
);

    localparam logic [1:0] CMD_STOP = 2'd0;
    localparam logic [1:0] CMD_FWD  = 2'd1;
    localparam logic [1:0] CMD_REV  = 2'd2;
    localparam logic [1:0] CMD_BRK  = 2'd3;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_UP    = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DOWN  = 3'd3;
    localparam logic [2:0] S_DEAD  = 3'd4;
    localparam logic [2:0] S_BRAKE = 3'd5;

    localparam int unsigned DW   = (DEAD_PER > 1) ? $clog2(DEAD_PER) : 1;
    localparam logic [8:0]  STEP = 9'(RAMP_STEP);

    logic [2:0]    state_q, state_d;
    logic [7:0]    duty_q,  duty_d;
    logic          dir_q,   dir_d;     // 0 fwd, 1 rev
    logic [DW-1:0] dead_q,  dead_d;
    logic          skip_q,  skip_d;    // dead time started mid-period

    logic [1:0] cmd;
    logic       want_move;
    logic       cmd_dir;
    logic [7:0] up_from_zero;
    logic       active;

    // Saturating step up, clamped at the target (never wraps past 255).
    function automatic logic [7:0] ramp_up(input logic [7:0] cur, input logic [7:0] tgt);
        logic [8:0] sum;
        sum = {1'b0, cur} + STEP;
        return (sum >= {1'b0, tgt}) ? tgt : sum[7:0];
    endfunction

    // Saturating step down, clamped at the floor; caller guarantees cur >= floor.
    function automatic logic [7:0] ramp_down(input logic [7:0] cur, input logic [7:0] floor);
        logic [8:0] gap;
        gap = {1'b0, cur} - {1'b0, floor};
        return (gap <= STEP) ? floor : (cur - STEP[7:0]);
    endfunction

    always_comb begin
        // A zero target cannot move the motor, so it is handled like stop.
        cmd = cmd_i;
        if ((target_i == '0) && ((cmd_i == CMD_FWD) || (cmd_i == CMD_REV))) begin
            cmd = CMD_STOP;
        end
        want_move    = (cmd == CMD_FWD) || (cmd == CMD_REV);
        cmd_dir      = (cmd == CMD_REV);
        up_from_zero = ramp_up('0, target_i);

        state_d = state_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
        dead_d  = dead_q;
        skip_d  = skip_q;

        if (cmd == CMD_BRK) begin
            state_d = S_BRAKE;
            duty_d  = '0;
        end else if (state_q == S_BRAKE) begin
            // Brake release is immediate; a partial first period is not
            // counted so the dead time is always DEAD_PER full periods.
            state_d = S_DEAD;
            dead_d  = '0;
            skip_d  = ~per_end_i;
        end else if (per_end_i) begin
            case (state_q)
                S_IDLE: begin
                    if (want_move) begin
                        dir_d   = cmd_dir;
                        duty_d  = up_from_zero;
                        state_d = (up_from_zero == target_i) ? S_RUN : S_UP;
                    end
                end
                S_UP, S_RUN, S_DOWN: begin
                    if (want_move && (cmd_dir == dir_q)) begin
                        // Same direction: move toward the target from either side.
                        if (duty_q < target_i) begin
                            duty_d  = ramp_up(duty_q, target_i);
                            state_d = (duty_d == target_i) ? S_RUN : S_UP;
                        end else if (duty_q > target_i) begin
                            duty_d  = ramp_down(duty_q, target_i);
                            state_d = (duty_d == target_i) ? S_RUN : S_DOWN;
                        end else begin
                            state_d = S_RUN;
                        end
                    end else begin
                        // Stop or reversal: ramp to zero in the current direction.
                        duty_d = ramp_down(duty_q, '0);
                        if (duty_d == '0) begin
                            state_d = want_move ? S_DEAD : S_IDLE;
                            dead_d  = '0;
                            skip_d  = 1'b0;
                        end else begin
                            state_d = S_DOWN;
                        end
                    end
                end
                S_DEAD: begin
                    // The dead time always runs out in full; a stop seen at its
                    // end parks the channel in IDLE instead of restarting.
                    if (skip_q) begin
                        skip_d = 1'b0;
                    end else if (dead_q == DW'(DEAD_PER - 1)) begin
                        if (want_move) begin
                            dir_d   = cmd_dir;
                            duty_d  = up_from_zero;
                            state_d = (up_from_zero == target_i) ? S_RUN : S_UP;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        dead_d = dead_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    duty_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            duty_q  <= '0;
            dir_q   <= 1'b0;
            dead_q  <= '0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
            dead_q  <= dead_d;
            skip_q  <= skip_d;
        end
    end

    // Only the latched direction's pin ever toggles; both high only in BRAKE.
    always_comb begin
        active  = (pwm_cnt_i < duty_q);
        pin_a_o = 1'b0;
        pin_b_o = 1'b0;
        case (state_q)
            S_UP, S_RUN, S_DOWN: begin
                pin_a_o = active & ~dir_q;
                pin_b_o = active &  dir_q;
            end
            S_BRAKE: begin
                pin_a_o = 1'b1;
                pin_b_o = 1'b1;
            end
            default: begin
                pin_a_o = 1'b0;
                pin_b_o = 1'b0;
            end
        endcase
        moving_o = (duty_q != '0) || (state_q == S_DEAD);
    end

endmodule

module motor_pwm_drive #(
    parameter int unsigned PRESCALE  = 196,
    parameter int unsigned RAMP_STEP = 8,
    parameter int unsigned DUTY_MAX  = 255,
    parameter int unsigned DEAD_PER  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_l,
    input  logic       in1_l,
    input  logic       in2_l,
    input  logic       en_r,
    input  logic       in1_r,
    input  logic       in2_r,
`ifdef MOTOR_SPEED_IN_EN
    input  logic [7:0] speed_l,
    input  logic [7:0] speed_r,
`endif
    output logic       pwm_la,
    output logic       pwm_lb,
    output logic       pwm_ra,
    output logic       pwm_rb,
    output logic       moving
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    pwm_q, pwm_d;
    logic          tick;
    logic          per_end;

    // Commands are decoded as they are registered: {in2,in1} lines up with
    // 0 stop, 1 fwd, 2 rev, 3 brake; a low enable forces stop.
    logic [1:0]    cmd_l_q, cmd_r_q;
    logic [7:0]    tgt_l,   tgt_r;
    logic          mov_l,   mov_r;

`ifdef MOTOR_SPEED_IN_EN
    logic [7:0]    speed_l_q, speed_r_q;
`endif

    always_comb begin
        tick    = (pre_q == PW'(PRESCALE - 1));
        pre_d   = tick ? '0 : (pre_q + 1'b1);
        pwm_d   = tick ? (pwm_q + 8'd1) : pwm_q;
        per_end = tick && (pwm_q == 8'hFF);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q   <= '0;
            pwm_q   <= '0;
            cmd_l_q <= '0;
            cmd_r_q <= '0;
`ifdef MOTOR_SPEED_IN_EN
            speed_l_q <= '0;
            speed_r_q <= '0;
`endif
        end else begin
            pre_q   <= pre_d;
            pwm_q   <= pwm_d;
            cmd_l_q <= en_l ? {in2_l, in1_l} : 2'd0;
            cmd_r_q <= en_r ? {in2_r, in1_r} : 2'd0;
`ifdef MOTOR_SPEED_IN_EN
            speed_l_q <= speed_l;
            speed_r_q <= speed_r;
`endif
        end
    end

`ifdef MOTOR_SPEED_IN_EN
    assign tgt_l = speed_l_q;
    assign tgt_r = speed_r_q;
`else
    assign tgt_l = 8'(DUTY_MAX);
    assign tgt_r = 8'(DUTY_MAX);
`endif

    motor_pwm_chan #(
        .RAMP_STEP (RAMP_STEP),
        .DEAD_PER  (DEAD_PER)
    ) u_chan_l (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_i     (cmd_l_q),
        .target_i  (tgt_l),
        .per_end_i (per_end),
        .pwm_cnt_i (pwm_q),
        .pin_a_o   (pwm_la),
        .pin_b_o   (pwm_lb),
        .moving_o  (mov_l)
    );

    motor_pwm_chan #(
        .RAMP_STEP (RAMP_STEP),
        .DEAD_PER  (DEAD_PER)
    ) u_chan_r (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_i     (cmd_r_q),
        .target_i  (tgt_r),
        .per_end_i (per_end),
        .pwm_cnt_i (pwm_q),
        .pin_a_o   (pwm_ra),
        .pin_b_o   (pwm_rb),
        .moving_o  (mov_r)
    );

    assign moving = mov_l | mov_r;

endmodule

// File: tb/tb_motor_pwm_drive.sv
// -----------------------------------------------------------------------------
// tb_motor_pwm_drive
//   Scoreboard bench for motor_pwm_drive with PRESCALE=1, RAMP_STEP=64,
//   DUTY_MAX=255, DEAD_PER=2 (one PWM period = 256 clk). The stimulus process
//   pushes, for each PWM period, the expected number of high cycles on every
//   bridge pin, the number of cycles with both left pins high, and the moving
//   level in the last cycle of the period. The monitor accumulates the pins
//   over each period and pops/compares at the period's last cycle.
// -----------------------------------------------------------------------------
module tb_motor_pwm_drive;

    localparam int PER = 256;

    logic clk = 1'b0;
    logic rst_n;
    logic en_l, in1_l, in2_l;
    logic en_r, in1_r, in2_r;
    logic pwm_la, pwm_lb, pwm_ra, pwm_rb, moving;
`ifdef MOTOR_SPEED_IN_EN
    logic [7:0] speed_l, speed_r;
`endif

    always #5 clk = ~clk;

    motor_pwm_drive #(
        .PRESCALE  (1),
        .RAMP_STEP (64),
        .DUTY_MAX  (255),
        .DEAD_PER  (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_l    (en_l),
        .in1_l   (in1_l),
        .in2_l   (in2_l),
        .en_r    (en_r),
        .in1_r   (in1_r),
        .in2_r   (in2_r),
`ifdef MOTOR_SPEED_IN_EN
        .speed_l (speed_l),
        .speed_r (speed_r),
`endif
        .pwm_la  (pwm_la),
        .pwm_lb  (pwm_lb),
        .pwm_ra  (pwm_ra),
        .pwm_rb  (pwm_rb),
        .moving  (moving)
    );

    typedef struct {
        int per;
        int la;
        int lb;
        int ra;
        int rb;
        int both;
        bit mov;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;      // clocks since reset release; cyc % 256 is the PWM phase
    int   pcount = 0;   // completed periods
    int   n_chk = 0;
    int   n_pass = 0;

    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int acc_la, acc_lb, acc_ra, acc_rb, acc_both;
    int ph;
    exp_t e;

    always @(negedge clk) begin
        ph = cyc % PER;
        if (ph == 0) begin
            acc_la = 0; acc_lb = 0; acc_ra = 0; acc_rb = 0; acc_both = 0;
        end
        acc_la   += int'(pwm_la);
        acc_lb   += int'(pwm_lb);
        acc_ra   += int'(pwm_ra);
        acc_rb   += int'(pwm_rb);
        acc_both += int'(pwm_la & pwm_lb);
        if (ph == PER - 1) begin
            while (q.size() > 0 && q[0].per < pcount) begin
                n_chk++;
                $display("FAIL period_%0d: expectation never reached a completed period", q[0].per);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].per == pcount) begin
                e = q.pop_front();
                n_chk++;
                if (acc_la == e.la && acc_lb == e.lb && acc_ra == e.ra && acc_rb == e.rb &&
                    acc_both == e.both && moving == e.mov) begin
                    n_pass++;
                end else begin
                    $display("FAIL period_%0d: got la=%0d lb=%0d ra=%0d rb=%0d both=%0d mov=%0b, want la=%0d lb=%0d ra=%0d rb=%0d both=%0d mov=%0b",
                             e.per, acc_la, acc_lb, acc_ra, acc_rb, acc_both, moving,
                             e.la, e.lb, e.ra, e.rb, e.both, e.mov);
                end
            end
            pcount++;
        end
    end

    task automatic next_period();
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while ((cyc % PER) != 0 && guard < 2 * PER);
    endtask

    task automatic to_phase(input int p);
        int guard = 0;
        while ((cyc % PER) != p && guard < 2 * PER) begin
            @(negedge clk);
            guard++;
        end
    endtask

    // Expect the current period's totals, then advance to the next period start.
    task automatic pe(input int la, input int lb, input int ra, input int rb,
                      input int both, input bit mov);
        exp_t x;
        x.per = pcount; x.la = la; x.lb = lb; x.ra = ra; x.rb = rb;
        x.both = both; x.mov = mov;
        q.push_back(x);
        next_period();
    endtask

    task automatic set_l(input bit en, input bit a, input bit b);
        en_l = en; in1_l = a; in2_l = b;
    endtask

    task automatic set_r(input bit en, input bit a, input bit b);
        en_r = en; in1_r = a; in2_r = b;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        set_l(0, 0, 0);
        set_r(0, 0, 0);
`ifdef MOTOR_SPEED_IN_EN
        speed_l = 8'd255;
        speed_r = 8'd255;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;               // this negedge is phase 0 of the first period

        // Soft start forward from IDLE: 0, 64, 128, 192, 255, hold.
        set_l(1, 1, 0);
        pe(  0, 0, 0, 0, 0, 0);
        pe( 64, 0, 0, 0, 0, 1);
        pe(128, 0, 0, 0, 0, 1);
        pe(192, 0, 0, 0, 0, 1);
        pe(255, 0, 0, 0, 0, 1);
        pe(255, 0, 0, 0, 0, 1);

        // Left reversal (ramp down, 2 dead periods, ramp up on B) while the
        // right channel soft-starts forward.
        set_l(1, 0, 1);
        set_r(1, 1, 0);
        pe(255,   0,   0, 0, 0, 1);
        pe(191,   0,  64, 0, 0, 1);
        pe(127,   0, 128, 0, 0, 1);
        pe( 63,   0, 192, 0, 0, 1);
        pe(  0,   0, 255, 0, 0, 1);
        pe(  0,   0, 255, 0, 0, 1);
        pe(  0,  64, 255, 0, 0, 1);
        pe(  0, 128, 255, 0, 0, 1);
        pe(  0, 192, 255, 0, 0, 1);
        pe(  0, 255, 255, 0, 0, 1);

        // Right soft stop to IDLE (no dead time), left keeps running reverse.
        set_r(0, 1, 0);
        pe(0, 255, 255, 0, 0, 1);
        pe(0, 255, 191, 0, 0, 1);
        pe(0, 255, 127, 0, 0, 1);
        pe(0, 255,  63, 0, 0, 1);

        // Brake applied at phase 100: pins 11 from phase 102 onward.
        begin
            exp_t x;
            x.per = pcount; x.la = 154; x.lb = 256; x.ra = 0; x.rb = 0;
            x.both = 154; x.mov = 1'b0;
            q.push_back(x);
            to_phase(100);
            set_l(1, 1, 1);
            next_period();
        end
        pe(256, 256, 0, 0, 256, 0);

        // Brake release to stop: 2 brake cycles, then dead time, then IDLE.
        set_l(1, 0, 0);
        pe(2, 2, 0, 0, 2, 1);
        pe(0, 0, 0, 0, 0, 1);
        pe(0, 0, 0, 0, 0, 1);

        // Start forward, then drop enable at duty 128: 64, 0, IDLE.
        set_l(1, 1, 0);
        pe(  0, 0, 0, 0, 0, 0);
        pe( 64, 0, 0, 0, 0, 1);
        set_l(0, 1, 0);
        pe(128, 0, 0, 0, 0, 1);
        pe( 64, 0, 0, 0, 0, 1);
        pe(  0, 0, 0, 0, 0, 0);

        // Reset pulse mid-ramp with the command still forward: restart at 64.
        set_l(1, 1, 0);
        pe(  0, 0, 0, 0, 0, 0);
        pe( 64, 0, 0, 0, 0, 1);
        to_phase(100);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;               // phase 0 of a fresh period
        pe(  0, 0, 0, 0, 0, 0);
        pe( 64, 0, 0, 0, 0, 1);
        pe(128, 0, 0, 0, 0, 1);

        n_chk++;
        if (q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
